// File: rtl/bram_sdp_bist_ctrl_pkg.sv
// Shared types, constants and the address-derived test pattern for the BRAM BIST sequencer.
package bram_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } bist_state_t;

    localparam logic [19:0] PAT_CONST = 20'h55000;
    localparam int          ERR_CNT_W = 16;

    // Pattern before truncation: v | v<<20 | PAT_CONST, optionally inverted, masked to width bits.
    function automatic logic [63:0] bist_pat(input logic [31:0] addr,
                                             input logic [31:0] offset,
                                             input logic        inv,
                                             input int unsigned width);
        logic [63:0] v;
        logic [63:0] p;
        logic [63:0] mask;
        v    = {32'd0, addr + offset};
        p    = v | (v << 20) | {44'd0, PAT_CONST};
        if (inv) begin
            p = ~p;
        end
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return p & mask;
    endfunction

endpackage

// File: rtl/bram_sdp_bist_ctrl_if.sv
// One half of a simple-dual-port BRAM: write port plus registered read port.
interface bram_sdp_bist_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 18
);
    logic                  wce;
    logic [ADDR_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0] wd;
    logic                  rce;
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rq;

    modport master (output wce, output wa, output wd, output rce, output ra, input rq);
    modport slave  (input wce, input wa, input wd, input rce, input ra, output rq);
endinterface

// File: rtl/bram_sdp_bist_ctrl_checker.sv
// Read-back checker: aligns expected data with the 1-cycle BRAM read latency and
// accumulates a saturating mismatch count plus the address of the first mismatch.
module bram_bist_checker
    import bram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  vld,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic [DATA_WIDTH-1:0] rq,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic [ERR_CNT_W-1:0]  err_cnt_nxt,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    logic                  vld_d;
    logic [DATA_WIDTH-1:0] exp_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  mismatch;

    // Case inequality so an undriven or unknown read word is reported as a failure.
    assign mismatch    = vld_d && (rq !== exp_d);
    assign err_cnt_nxt = (mismatch && (err_cnt != '1)) ? err_cnt + ERR_CNT_W'(1) : err_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_d          <= 1'b0;
            exp_d          <= '0;
            addr_d         <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            vld_d  <= vld;
            exp_d  <= exp_data;
            addr_d <= addr;
            if (clear) begin
                err_cnt        <= '0;
                first_err_addr <= '0;
            end else begin
                err_cnt <= err_cnt_nxt;
                if (mismatch && (err_cnt == '0)) begin
                    first_err_addr <= addr_d;
                end
            end
        end
    end

endmodule

// File: rtl/bram_sdp_bist_ctrl.sv
// BIST sequencer for one BRAM half: write a pattern over a window, read it back, count mismatches.
// Optional BRAM_BIST_INV_PASS_EN adds a second write/read pass with the inverted pattern.
//   state | meaning
//   IDLE  | waiting for start; results held
//   WRITE | one pattern word written per cycle across the window
//   READ  | one word read per cycle; checker compares a cycle later
//   DRAIN | compare of the final read word, then done
module bram_sdp_bist_ctrl
    import bram_bist_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 18,
    parameter int BASE_ADDR   = 0,
    parameter int DEPTH       = 512,
    parameter int DATA_OFFSET = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    bram_sdp_bist_ctrl_if.master  bram
);

    if ((DEPTH < 1) || (BASE_ADDR + DEPTH > (1 << ADDR_WIDTH))) begin : g_bad_window
        $error("bram_sdp_bist_ctrl: test window exceeds BRAM address space");
    end

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_OFS = ADDR_WIDTH'(DEPTH - 1);

    bist_state_t           state;
    bist_state_t           state_nxt;
    logic [ADDR_WIDTH-1:0] rem;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  last;
    logic                  accept;
    logic                  inv;
    logic [63:0]           pat;
    logic                  unused_pat;
    logic [ERR_CNT_W-1:0]  err_cnt_nxt;

    // rem counts down to the terminal word of the phase; address walks upward from BASE.
    assign last       = (rem == '0);
    assign addr       = BASE + (LAST_OFS - rem);
    assign accept     = (state == IDLE) && start && !done;
    assign busy       = (state != IDLE);
    assign unused_pat = ^pat[63:DATA_WIDTH];

`ifdef BRAM_BIST_INV_PASS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inv <= 1'b0;
        end else if (accept) begin
            inv <= 1'b0;
        end else if ((state == READ) && last) begin
            inv <= 1'b1;
        end
    end
`else
    assign inv = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = WRITE;
            WRITE: if (last) state_nxt = READ;
`ifdef BRAM_BIST_INV_PASS_EN
            READ:  if (last) state_nxt = inv ? DRAIN : WRITE;
`else
            READ:  if (last) state_nxt = DRAIN;
`endif
            DRAIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pat      = bist_pat(32'(addr), 32'(DATA_OFFSET), inv, DATA_WIDTH);
        bram.wce = 1'b0;
        bram.wa  = '0;
        bram.wd  = '0;
        bram.rce = 1'b0;
        bram.ra  = '0;
        case (state)
            WRITE: begin
                bram.wce = 1'b1;
                bram.wa  = addr;
                bram.wd  = pat[DATA_WIDTH-1:0];
            end
            READ: begin
                bram.rce = 1'b1;
                bram.ra  = addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem  <= '0;
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            done <= (state == DRAIN);
            if (state_nxt != state) begin
                rem <= LAST_OFS;
            end else if (!last) begin
                rem <= rem - ADDR_WIDTH'(1);
            end
            if (accept) begin
                pass <= 1'b0;
            end else if (state == DRAIN) begin
                pass <= (err_cnt_nxt == '0);
            end
        end
    end

    bram_bist_checker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_chk (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (accept),
        .vld            (bram.rce),
        .addr           (bram.ra),
        .exp_data       (pat[DATA_WIDTH-1:0]),
        .rq             (bram.rq),
        .err_cnt        (err_cnt),
        .err_cnt_nxt    (err_cnt_nxt),
        .first_err_addr (first_err_addr)
    );

endmodule

// File: tb/tb_bram_sdp_bist_ctrl.sv
// Bench for bram_sdp_bist_ctrl: two instances share one behavioural BRAM (lower and upper half);
// run results go through a scoreboard queue, write/read address streams are checked on the fly.
module tb_bram_sdp_bist_ctrl;
    localparam int AW = 10;
    localparam int DW = 18;
    localparam int D  = 512;
`ifdef BRAM_BIST_INV_PASS_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif
    localparam int LAT = 2 * NPASS * D + 2;

    typedef struct {
        int sel;
        bit pass;
        int err;
        int first;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_s [2];
    logic busy_s [2];
    logic done_s [2];
    logic pass_s [2];
    logic [15:0] err_s [2];
    logic [AW-1:0] fea_s [2];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    exp_t sbq[$];

    logic [DW-1:0] mem [0:1023];
    bit wr_seen [0:1023];
    int stuck_addr = -1;
    int x_lo = -1;
    int x_hi = -2;

    logic prev_w [2];
    logic prev_r [2];
    logic [AW-1:0] prev_wa [2];
    logic [AW-1:0] prev_ra [2];

    bram_sdp_bist_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b0 ();
    bram_sdp_bist_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1 ();

    bram_sdp_bist_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(0), .DEPTH(D), .DATA_OFFSET(0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .pass(pass_s[0]), .err_cnt(err_s[0]), .first_err_addr(fea_s[0]), .bram(b0)
    );

    bram_sdp_bist_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(512), .DEPTH(D), .DATA_OFFSET(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .pass(pass_s[1]), .err_cnt(err_s[1]), .first_err_addr(fea_s[1]), .bram(b1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat_m(input int a, input int off, input bit inv);
        logic [31:0] v;
        logic [31:0] p;
        v = a + off;
        p = v | (v << 20) | 32'h0005_5000;
        if (inv) p = ~p;
        return p[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rd_m(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        d = mem[a];
        if (int'(a) >= x_lo && int'(a) <= x_hi) d = 'x;
        if (int'(a) == stuck_addr) d[0] = 1'b0;
        return d;
    endfunction

    always @(posedge clk) begin
        if (b0.wce) mem[b0.wa] <= b0.wd;
        if (b1.wce) mem[b1.wa] <= b1.wd;
        if (b0.rce) b0.rq <= rd_m(b0.ra);
        if (b1.rce) b1.rq <= rd_m(b1.ra);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Address streams must start at the window base and step by one; write data must match the model.
    task automatic mon(input int sel, input logic wce, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rce, input logic [AW-1:0] ra);
        logic [AW-1:0] base;
        logic [AW-1:0] ew;
        logic [AW-1:0] er;
        bit inv;
        base = (sel == 1) ? AW'(512) : AW'(0);
        ew = prev_w[sel] ? AW'(prev_wa[sel] + AW'(1)) : base;
        er = prev_r[sel] ? AW'(prev_ra[sel] + AW'(1)) : base;
        if (wce) begin
            inv = wr_seen[wa];
            wr_seen[wa] = 1'b1;
            chk("wa_seq", 32'(wa), 32'(ew));
            chk("wd_pat", 32'(wd), 32'(pat_m(int'(wa), sel, inv)));
            if (sel == 0 && wa == 3 && !inv) chk("wd_addr3", 32'(wd), 32'h15003);
            if (sel == 1 && wa == 512) begin
                if (inv) chk("wd_512_inv", 32'(wd), 32'h2ADFE);
                else     chk("wd_512", 32'(wd), 32'h15201);
            end
        end
        if (rce) chk("ra_seq", 32'(ra), 32'(er));
        prev_w[sel]  = wce;
        prev_wa[sel] = wa;
        prev_r[sel]  = rce;
        prev_ra[sel] = ra;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, b0.wce, b0.wa, b0.wd, b0.rce, b0.ra);
            mon(1, b1.wce, b1.wa, b1.wd, b1.rce, b1.ra);
        end else begin
            prev_w = '{1'b0, 1'b0};
            prev_r = '{1'b0, 1'b0};
        end
    end

    task automatic clear_seen();
        for (int i = 0; i < 1024; i++) wr_seen[i] = 1'b0;
    endtask

    // Start a run, push its expected result, and pop/compare it when done pulses.
    // start is also raised during the done cycle, which must not launch another run.
    task automatic run(input int sel, input bit ep, input int ee, input int ef, input int g1, input int g2);
        exp_t x;
        exp_t y;
        int t0;
        int ndone;
        bit seen;
        x.sel = sel; x.pass = ep; x.err = ee; x.first = ef; x.lat = LAT;
        sbq.push_back(x);
        clear_seen();
        @(negedge clk);
        start_s[sel] = 1'b1;
        t0 = cyc;
        ndone = 0;
        seen = 1'b0;
        for (int k = 1; k <= LAT + 50 && !seen; k++) begin
            @(negedge clk);
            start_s[sel] = (k == g1 || k == g2);
            if (done_s[sel]) begin
                seen = 1'b1;
                ndone++;
                y = sbq.pop_front();
                chk("latency", 32'(cyc - t0), 32'(y.lat));
                chk("pass", 32'(pass_s[sel]), 32'(y.pass));
                chk("err_cnt", 32'(err_s[sel]), 32'(y.err));
                chk("first_err_addr", 32'(fea_s[sel]), 32'(y.first));
                chk("busy_at_done", 32'(busy_s[sel]), 32'd0);
                start_s[sel] = 1'b1;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (!seen) void'(sbq.pop_front());
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start_s[sel] = 1'b0;
            if (done_s[sel]) ndone++;
        end
        chk("single_done", 32'(ndone), 32'd1);
        chk("idle_after_done", 32'(busy_s[sel]), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        start_s = '{1'b0, 1'b0};
        prev_w = '{1'b0, 1'b0};
        prev_r = '{1'b0, 1'b0};
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        clear_seen();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_s[0]), 32'd0);
        chk("rst_done", 32'(done_s[0]), 32'd0);
        chk("rst_pass", 32'(pass_s[0]), 32'd0);
        chk("rst_wce", 32'(b0.wce), 32'd0);
        chk("rst_rce", 32'(b0.rce), 32'd0);
        chk("rst_err", 32'(err_s[0]), 32'd0);
        chk("rst_fea", 32'(fea_s[0]), 32'd0);
        chk("rst_wa", 32'(b0.wa), 32'd0);
        chk("rst_wd", 32'(b0.wd), 32'd0);
        chk("rst_ra", 32'(b0.ra), 32'd0);
        chk("rst_busy1", 32'(busy_s[1]), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(0, 1'b1, 0, 0, -1, -1);

        stuck_addr = 7;
        run(0, 1'b0, 1, 7, -1, -1);
        stuck_addr = -1;

        x_lo = 100;
        x_hi = 102;
        run(0, 1'b0, 3 * NPASS, 100, -1, -1);
        x_lo = -1;
        x_hi = -2;

        run(0, 1'b1, 0, 0, 5, 300);

        // Reset in the middle of the write phase, then a clean run.
        clear_seen();
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (198) @(negedge clk);
        chk("pre_rst_wce", 32'(b0.wce), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_wce", 32'(b0.wce), 32'd0);
        chk("midrst_busy", 32'(busy_s[0]), 32'd0);
        chk("midrst_err", 32'(err_s[0]), 32'd0);
        chk("midrst_pass", 32'(pass_s[0]), 32'd0);
        nd = 0;
        for (int k = 0; k < LAT + 20; k++) begin
            @(negedge clk);
            if (done_s[0]) nd++;
        end
        chk("midrst_no_done", 32'(nd), 32'd0);
        run(0, 1'b1, 0, 0, -1, -1);

        run(1, 1'b1, 0, 0, -1, -1);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
